pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: sequences instruction-memory requests, selects the next PC
// (trap > redirect > pending redirect > PC+4) and holds the fetched instruction while decode stalls.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic        PCEn,
    output logic [31:0] PCNext,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap
);

    localparam int unsigned XLEN       = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

    logic [XLEN-1:0] trap_addr_c;
    logic [XLEN-1:0] redir_addr_c;
    logic [XLEN-1:0] seq_addr_c;
    logic [XLEN-1:0] sel_addr_c;
    logic            redir_any_c;
    logic            pend_is_trap_c;

    // Word-aligned targets and next-PC selection shared by FETCH completion and HOLD release
    always_comb begin
        trap_addr_c    = TRAP_VECTOR & ALIGN_MASK;
        redir_addr_c   = redirect_target & ALIGN_MASK;
        seq_addr_c     = PC + PC_STEP;
        redir_any_c    = trap | redirect_valid | pend_q;
        pend_is_trap_c = pend_q && (pend_tgt_q == trap_addr_c);
        if (trap) begin
            sel_addr_c = trap_addr_c;
        end else if (redirect_valid) begin
            sel_addr_c = redir_addr_c;
        end else if (pend_q) begin
            sel_addr_c = pend_tgt_q;
        end else begin
            sel_addr_c = seq_addr_c;
        end
    end

    // State register plus the single pending redirect/trap slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Next-state and output decode; everything is forced quiet while reset is asserted
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        PCEn        = 1'b0;
        PCNext      = '0;
        imem_req    = 1'b0;
        imem_addr   = PC;
        instr_valid = 1'b0;

        if (reset) begin
            unique case (state_q)
                ST_BOOT: begin
                    PCEn    = 1'b1;
                    PCNext  = RESET_VECTOR;
                    state_d = ST_FETCH;
                end

                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        if (redir_any_c) begin
                            // Fetched instruction is on the wrong path: drop it and steer
                            PCEn   = 1'b1;
                            PCNext = sel_addr_c;
                            pend_d = 1'b0;
                        end else begin
                            instr_valid = 1'b1;
                            if (stall) begin
                                state_d = ST_HOLD;
                            end else begin
                                PCEn   = 1'b1;
                                PCNext = seq_addr_c;
                            end
                        end
                    end else if (trap) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = trap_addr_c;
                    end else if (redirect_valid && !pend_is_trap_c) begin
                        // A stored trap must not be displaced by a younger redirect
                        pend_d     = 1'b1;
                        pend_tgt_d = redir_addr_c;
                    end
                end

                ST_HOLD: begin
                    if (trap) begin
                        PCEn    = 1'b1;
                        PCNext  = trap_addr_c;
                        pend_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else if (!stall) begin
                        PCEn    = 1'b1;
                        PCNext  = sel_addr_c;
                        pend_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else if (redirect_valid) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = redir_addr_c;
                    end
                end

                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl; the bench owns the PC register and scores
// each cycle's decoded outputs against a queue of hand-derived expectations.
module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic        en;
        logic [31:0] nxt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc = 32'h1234_5670;
    logic        PCEn;
    logic [31:0] PCNext;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        instr_valid;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    pc_fetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .PC              (pc),
        .PCEn            (PCEn),
        .PCNext          (PCNext),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register driven by the DUT's load enable
    always @(posedge clk) begin
        if (PCEn) pc <= PCNext;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, score them at the falling edge
    task automatic cyc(input string tag, input logic rdy, input logic stl, input logic rv,
                       input logic [31:0] rt, input logic tr,
                       input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                       input logic e_en, input logic [31:0] e_next);
        exp_t e;
        exp_t o;
        imem_ready      = rdy;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = rt;
        trap            = tr;
        e.req  = e_req;
        e.addr = e_addr;
        e.iv   = e_iv;
        e.en   = e_en;
        e.nxt  = e_next;
        exp_q.push_back(e);
        @(negedge clk);
        o = exp_q.pop_front();
        chk({tag, ".req"}, 32'(imem_req), 32'(o.req));
        if (o.req) chk({tag, ".addr"}, imem_addr, o.addr);
        chk({tag, ".iv"}, 32'(instr_valid), 32'(o.iv));
        chk({tag, ".en"}, 32'(PCEn), 32'(o.en));
        if (o.en) chk({tag, ".next"}, PCNext, o.nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag, input logic [31:0] e_addr);
        chk({tag, ".req"}, 32'(imem_req), 32'd0);
        chk({tag, ".en"}, 32'(PCEn), 32'd0);
        chk({tag, ".next"}, PCNext, 32'd0);
        chk({tag, ".iv"}, 32'(instr_valid), 32'd0);
        chk({tag, ".addr"}, imem_addr, e_addr);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        imem_ready      = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap            = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst", 32'h1234_5670);
        @(posedge clk);
        #1;
        reset = 1'b1;

        //   tag        rdy stl rv  target         tr  req addr          iv en next
        cyc("boot",     1, 0, 0, 32'h0,          0,  0, 32'h0,         0, 1, 32'h0);
        cyc("seq0",     1, 0, 0, 32'h0,          0,  1, 32'h0,         1, 1, 32'h4);
        cyc("seq4",     1, 0, 0, 32'h0,          0,  1, 32'h4,         1, 1, 32'h8);
        cyc("seq8",     1, 0, 0, 32'h0,          0,  1, 32'h8,         1, 1, 32'hC);
        cyc("seq12",    1, 0, 0, 32'h0,          0,  1, 32'hC,         1, 1, 32'h10);

        cyc("wait1",    0, 0, 0, 32'h0,          0,  1, 32'h10,        0, 0, 32'h0);
        cyc("wait2",    0, 0, 0, 32'h0,          0,  1, 32'h10,        0, 0, 32'h0);
        cyc("wait3",    0, 0, 0, 32'h0,          0,  1, 32'h10,        0, 0, 32'h0);
        cyc("waitdone", 1, 0, 0, 32'h0,          0,  1, 32'h10,        1, 1, 32'h14);
        cyc("to18",     1, 0, 0, 32'h0,          0,  1, 32'h14,        1, 1, 32'h18);
        cyc("to1c",     1, 0, 0, 32'h0,          0,  1, 32'h18,        1, 1, 32'h1C);
        cyc("to20",     1, 0, 0, 32'h0,          0,  1, 32'h1C,        1, 1, 32'h20);

        cyc("redir_st", 0, 0, 1, 32'h83,         0,  1, 32'h20,        0, 0, 32'h0);
        cyc("redir_w",  0, 0, 0, 32'h0,          0,  1, 32'h20,        0, 0, 32'h0);
        cyc("redir_cp", 1, 0, 0, 32'h0,          0,  1, 32'h20,        0, 1, 32'h80);
        cyc("at80",     1, 0, 0, 32'h0,          0,  1, 32'h80,        1, 1, 32'h84);
        cyc("redir_nw", 1, 0, 1, 32'h40,         0,  1, 32'h84,        0, 1, 32'h40);

        cyc("stall_cp", 1, 1, 0, 32'h0,          0,  1, 32'h40,        1, 0, 32'h0);
        cyc("hold_rd",  1, 1, 1, 32'h200,        0,  0, 32'h0,         0, 0, 32'h0);
        cyc("hold2",    1, 1, 0, 32'h0,          0,  0, 32'h0,         0, 0, 32'h0);
        cyc("hold3",    1, 1, 0, 32'h0,          0,  0, 32'h0,         0, 0, 32'h0);
        cyc("hold_rel", 1, 0, 0, 32'h0,          0,  0, 32'h0,         0, 1, 32'h200);
        cyc("at200",    1, 0, 0, 32'h0,          0,  1, 32'h200,       1, 1, 32'h204);

        cyc("stall2",   1, 1, 0, 32'h0,          0,  1, 32'h204,       1, 0, 32'h0);
        cyc("hold_trp", 1, 1, 0, 32'h0,          1,  0, 32'h0,         0, 1, 32'h100);
        cyc("at100",    1, 0, 0, 32'h0,          0,  1, 32'h100,       1, 1, 32'h104);
        cyc("trp_rd",   1, 0, 1, 32'h300,        1,  1, 32'h104,       0, 1, 32'h100);

        cyc("ptrap_a",  0, 0, 0, 32'h0,          1,  1, 32'h100,       0, 0, 32'h0);
        cyc("ptrap_b",  0, 0, 1, 32'h500,        0,  1, 32'h100,       0, 0, 32'h0);
        cyc("ptrap_c",  1, 0, 0, 32'h0,          0,  1, 32'h100,       0, 1, 32'h100);
        cyc("prd_a",    0, 0, 1, 32'h600,        0,  1, 32'h100,       0, 0, 32'h0);
        cyc("prd_b",    0, 0, 0, 32'h0,          1,  1, 32'h100,       0, 0, 32'h0);
        cyc("prd_c",    1, 0, 0, 32'h0,          0,  1, 32'h100,       0, 1, 32'h100);

        cyc("to_top",   1, 0, 1, 32'hFFFF_FFFE,  0,  1, 32'h100,       0, 1, 32'hFFFF_FFFC);
        cyc("wrap",     1, 0, 0, 32'h0,          0,  1, 32'hFFFF_FFFC, 1, 1, 32'h0);
        cyc("mid_wait", 0, 0, 0, 32'h0,          0,  1, 32'h0,         0, 0, 32'h0);

        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst", 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        cyc("reboot",   1, 0, 0, 32'h0,          0,  0, 32'h0,         0, 1, 32'h0);
        cyc("refetch",  1, 0, 0, 32'h0,          0,  1, 32'h0,         1, 1, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
